sync_deserializer: RTL and testbench

SYNC_DESERIALIZER -- requirements
Module: sync_deserializer

---
 rtl/sync_deserializer.sv | 114 +++++++++++
 tb/tb_sync_deserializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_deserializer.sv
// Serial-to-byte deserializer fed LSB-first from a FIFO. It hunts for a sync
// marker, then emits FRAME_LEN data bytes between consecutive markers.
module sync_deserializer #(
    parameter logic [7:0]  SYNC_WORD = 8'hBC,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Empty,
    input  logic       i_Data_In,
    output logic       o_R_en,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_Locked,
    output logic       o_Sync_Err,
    output logic [7:0] o_Err_Cnt
);

    localparam logic [7:0] FrameLen = 8'(FRAME_LEN);

    typedef enum logic {StHunt, StLocked} state_e;

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] data_q, data_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       valid_q, valid_d;
    logic       sync_err_q, sync_err_d;
    logic       locked_q;
    logic       rd_pend_q;
    logic [7:0] shifted;

    assign o_R_en  = !i_Empty && !i_Rst;
    assign shifted = {i_Data_In, shreg_q[7:1]};

    assign o_Data     = data_q;
    assign o_Valid    = valid_q;
    assign o_Locked   = locked_q;
    assign o_Sync_Err = sync_err_q;
    assign o_Err_Cnt  = err_cnt_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        err_cnt_d  = err_cnt_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;

        // Read data is only valid the cycle after a read was issued.
        if (rd_pend_q) begin
            shreg_d = shifted;
            unique case (state_q)
                StHunt: begin
                    if (shifted == SYNC_WORD) begin
                        state_d    = StLocked;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 8'd0;
                    end
                end
                StLocked: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q < FrameLen) begin
                            data_d     = shifted;
                            valid_d    = 1'b1;
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end else if (shifted == SYNC_WORD) begin
                            byte_cnt_d = 8'd0;
                        end else begin
                            sync_err_d = 1'b1;
                            state_d    = StHunt;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= StHunt;
            shreg_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            data_q     <= 8'd0;
            err_cnt_q  <= 8'd0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            locked_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            err_cnt_q  <= err_cnt_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
            locked_q   <= (state_q == StLocked);
            rd_pend_q  <= o_R_en;
        end
    end

endmodule

// File: tb/tb_sync_deserializer.sv
// Bench for sync_deserializer: a FIFO model feeds two instances (frame lengths
// 16 and 2) from one bit stream; received bytes and error pulses are collected.
module tb_sync_deserializer;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Empty = 1'b1;
    logic       i_Data_In = 1'b0;

    logic       r_en_a, valid_a, locked_a, serr_a;
    logic [7:0] data_a, ecnt_a;
    logic       r_en_b, valid_b, locked_b, serr_b;
    logic [7:0] data_b, ecnt_b;

    always #5 i_Clk = ~i_Clk;

    sync_deserializer dut_a (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Empty    (i_Empty),
        .i_Data_In  (i_Data_In),
        .o_R_en     (r_en_a),
        .o_Data     (data_a),
        .o_Valid    (valid_a),
        .o_Locked   (locked_a),
        .o_Sync_Err (serr_a),
        .o_Err_Cnt  (ecnt_a)
    );

    sync_deserializer #(.FRAME_LEN(2)) dut_b (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Empty    (i_Empty),
        .i_Data_In  (i_Data_In),
        .o_R_en     (r_en_b),
        .o_Data     (data_b),
        .o_Valid    (valid_b),
        .o_Locked   (locked_b),
        .o_Sync_Err (serr_b),
        .o_Err_Cnt  (ecnt_b)
    );

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] tr;
        logic       exp_err;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ren_viol = 0;
    int         erra = 0;
    int         errb = 0;
    int         last_rd_cyc = 0;
    int         last_va_cyc = 0;
    bit         bitq[$];
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         rd_flag = 1'b0;
    bit         cur_bit = 1'b0;

    always @(posedge i_Clk) begin
        cyc <= cyc + 1;
        if ((r_en_a || r_en_b) && i_Empty) ren_viol <= ren_viol + 1;
    end

    // Collect outputs just after the falling edge, once the driver has settled.
    always @(negedge i_Clk) begin
        #1;
        if (i_Rst) begin
            qa.delete();
            qb.delete();
            erra = 0;
            errb = 0;
        end else begin
            if (valid_a === 1'b1) begin
                qa.push_back(data_a);
                last_va_cyc = cyc;
            end
            if (valid_b === 1'b1) qb.push_back(data_b);
            if (serr_a === 1'b1) erra++;
            if (serr_b === 1'b1) errb++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Rst = 1'b1;
        i_Empty = 1'b0;
        i_Data_In = 1'b1;
        rd_flag = 1'b0;
        #1 check("ren_in_reset", 32'(r_en_a), 32'd0);
        @(negedge i_Clk);
        i_Rst = 1'b0;
        i_Empty = 1'b1;
        bitq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_Clk);
            i_Empty = 1'b1;
            i_Data_In = 1'($urandom);
        end
        #2;
    endtask

    // FIFO model: one bit per read, returned the cycle after the read.
    task automatic run(input bit stall, input int limit);
        int reads = 0;
        int guard = 0;
        while ((bitq.size() != 0 && reads < limit) || rd_flag) begin
            @(negedge i_Clk);
            i_Data_In = rd_flag ? cur_bit : 1'($urandom);
            i_Empty = (bitq.size() == 0) || (reads >= limit) ||
                      (stall && ($urandom_range(0, 2) == 0));
            rd_flag = !i_Empty;
            if (rd_flag) begin
                cur_bit = bitq.pop_front();
                reads++;
                last_rd_cyc = cyc;
            end
            guard++;
            if (guard > 50000) begin
                check("run_timeout", 32'(guard), 32'd0);
                rd_flag = 1'b0;
                return;
            end
        end
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{d0: 8'h11, d1: 8'h22, tr: 8'h55, exp_err: 1'b1};
        vecs[1] = '{d0: 8'hA5, d1: 8'hBC, tr: 8'hBC, exp_err: 1'b0};
        vecs[2] = '{d0: 8'h00, d1: 8'hFF, tr: 8'hBC, exp_err: 1'b0};
        vecs[3] = '{d0: 8'h3C, d1: 8'hC3, tr: 8'hBD, exp_err: 1'b1};

        // Reset state
        do_reset();
        idle(1);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_locked", 32'(locked_a), 32'd0);
        check("rst_serr", 32'(serr_a), 32'd0);
        check("rst_ecnt", 32'(ecnt_a), 32'd0);

        // Full frame of 16 bytes after the marker
        do_reset();
        push_byte(8'hBC);
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        run(1'b0, 100000);
        idle(3);
        check("frame_count", 32'(qa.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("frame_byte%0d", i),
                  (qa.size() > i) ? 32'(qa[i]) : 32'hDEAD, 32'(i));
        check("frame_locked", 32'(locked_a), 32'd1);
        check("frame_serr", 32'(erra), 32'd0);

        // Garbage bits ahead of the marker, plus latency of the single byte
        do_reset();
        for (int i = 0; i < 3; i++) bitq.push_back(1'($urandom));
        push_byte(8'hBC);
        push_byte(8'hA5);
        run(1'b0, 100000);
        idle(3);
        check("garbage_count", 32'(qa.size()), 32'd1);
        check("garbage_byte", (qa.size() > 0) ? 32'(qa[0]) : 32'hDEAD, 32'hA5);
        check("latency", 32'(last_va_cyc - last_rd_cyc), 32'd2);

        // Short frames on the FRAME_LEN=2 instance
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push_byte(8'hBC);
            push_byte(vecs[v].d0);
            push_byte(vecs[v].d1);
            push_byte(vecs[v].tr);
            run(1'b0, 100000);
            idle(3);
            check($sformatf("vec%0d_count", v), 32'(qb.size()), 32'd2);
            check($sformatf("vec%0d_b0", v),
                  (qb.size() > 0) ? 32'(qb[0]) : 32'hDEAD, 32'(vecs[v].d0));
            check($sformatf("vec%0d_b1", v),
                  (qb.size() > 1) ? 32'(qb[1]) : 32'hDEAD, 32'(vecs[v].d1));
            check($sformatf("vec%0d_serr", v), 32'(errb), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_ecnt", v), 32'(ecnt_b), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_locked", v), 32'(locked_b), 32'(!vecs[v].exp_err));
        end

        // Random FIFO stalls; a data byte equal to the marker
        do_reset();
        push_byte(8'hBC);
        push_byte(8'h3C);
        push_byte(8'hBC);
        run(1'b1, 100000);
        idle(3);
        check("stall_count", 32'(qa.size()), 32'd2);
        check("stall_b0", (qa.size() > 0) ? 32'(qa[0]) : 32'hDEAD, 32'h3C);
        check("stall_b1", (qa.size() > 1) ? 32'(qa[1]) : 32'hDEAD, 32'hBC);
        check("stall_locked", 32'(locked_a), 32'd1);
        check("ren_while_empty", 32'(ren_viol), 32'd0);

        // Error counter saturation on the FRAME_LEN=2 instance
        do_reset();
        for (int i = 0; i < 254; i++) begin
            push_byte(8'hBC);
            push_byte(8'h11);
            push_byte(8'h22);
            push_byte(8'h55);
        end
        run(1'b0, 100000);
        idle(3);
        check("ecnt_254", 32'(ecnt_b), 32'hFE);
        for (int i = 0; i < 46; i++) begin
            push_byte(8'hBC);
            push_byte(8'h11);
            push_byte(8'h22);
            push_byte(8'h55);
        end
        run(1'b0, 100000);
        idle(3);
        check("ecnt_sat", 32'(ecnt_b), 32'hFF);
        check("serr_pulses", 32'(errb), 32'd300);

        // Reset in the middle of a data byte, then relock
        do_reset();
        push_byte(8'hBC);
        push_byte(8'h12);
        push_byte(8'h34);
        run(1'b0, 21);
        idle(2);
        check("mid_pre_locked", 32'(locked_a), 32'd1);
        check("mid_pre_byte", (qa.size() > 0) ? 32'(qa[0]) : 32'hDEAD, 32'h12);
        do_reset();
        idle(1);
        check("mid_data", 32'(data_a), 32'd0);
        check("mid_valid", 32'(valid_a), 32'd0);
        check("mid_locked", 32'(locked_a), 32'd0);
        check("mid_ecnt_b", 32'(ecnt_b), 32'd0);
        check("mid_qempty", 32'(qa.size()), 32'd0);
        push_byte(8'hBC);
        push_byte(8'h77);
        run(1'b0, 100000);
        idle(3);
        check("relock_count", 32'(qa.size()), 32'd1);
        check("relock_byte", (qa.size() > 0) ? 32'(qa[0]) : 32'hDEAD, 32'h77);
        check("relock_locked", 32'(locked_a), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
